// File: rtl/nibble_serial_add_ctrl_if.sv
// Bus bundle for nibble_serial_add_ctrl: operation request/response plus shared 4-bit adder.
// Optional subtract control appears only when NIBBLE_SUB_EN is defined.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef NIBBLE_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  modport master (
    output start, op_a, op_b, cin,
`ifdef NIBBLE_SUB_EN
    output sub,
`endif
    output add_sum, add_cout,
    input  busy, done, result, cout, add_a, add_b, add_cin
  );

  modport slave (
    input  start, op_a, op_b, cin,
`ifdef NIBBLE_SUB_EN
    input  sub,
`endif
    input  add_sum, add_cout,
    output busy, done, result, cout, add_a, add_b, add_cin
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller: sequences a W-bit add through one shared 4-bit adder.
// Define NIBBLE_SUB_EN to add the subtract mode (inverted op_b, forced carry-in).
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
`ifdef NIBBLE_SUB_EN
  logic          sub_q, sub_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef NIBBLE_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef NIBBLE_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    cout_d      = cout_q;
`ifdef NIBBLE_SUB_EN
    sub_d       = sub_q;
`endif
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = ADD;
          a_d      = bus.op_a;
          b_d      = bus.op_b;
          cin_d    = bus.cin;
`ifdef NIBBLE_SUB_EN
          sub_d    = bus.sub;
`endif
          idx_d    = '0;
          carry_d  = 1'b0;
          result_d = '0;
          cout_d   = 1'b0;
        end
      end
      ADD: begin
        bus.add_a   = a_q[{idx_q, 2'b00} +: 4];
        bus.add_b   = b_q[{idx_q, 2'b00} +: 4];
        bus.add_cin = (idx_q == '0) ? cin_q : carry_q;
`ifdef NIBBLE_SUB_EN
        // Two's-complement subtract: a + ~b + 1, so cout=1 means no borrow.
        if (sub_q) begin
          bus.add_b   = ~b_q[{idx_q, 2'b00} +: 4];
          bus.add_cin = (idx_q == '0) ? 1'b1 : carry_q;
        end
`endif
        result_d[{idx_q, 2'b00} +: 4] = bus.add_sum;
        carry_d = bus.add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NIBBLES - 1)) begin
          state_d = DONE;
          cout_d  = bus.add_cout;
          idx_d   = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl (NIBBLES=4) with a behavioural shared adder.
// Subtract vectors are exercised when NIBBLE_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;
  int   n_done;

  nibble_serial_add_ctrl_if #(.NIBBLES(4)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign {bus.add_cout, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
`ifdef NIBBLE_SUB_EN
    bus.sub   = s;
`else
    if (s) $display("note: sub requested without subtract support");
`endif
  endtask

  // Start sampled at edge k; done must be high only after edge k+4 (cycle k+5).
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic [15:0] er, input logic ec);
    set_op(a, b, c, s);
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy0"}, 32'(bus.busy), 32'd1);
    chk({tag, "_adda0"}, 32'(bus.add_a), 32'(a[3:0]));
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4) chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busyd"}, 32'(bus.busy), 32'd1);
    chk({tag, "_res"}, 32'(bus.result), 32'(er));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    chk({tag, "_addidle"}, 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
    tick();
    chk({tag, "_idle"}, 32'({bus.busy, bus.done}), 32'd0);
    chk({tag, "_hold"}, 32'({bus.cout, bus.result}), 32'({ec, er}));
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.cin = 1'b0;
`ifdef NIBBLE_SUB_EN
    bus.sub = 1'b0;
`endif
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_res", 32'(bus.result), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_adder", 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
    rst = 1'b0;
    tick();

    run_op("a1", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0);
    run_op("ovf", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0);

    // Start held high through the whole first operation.
    set_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    n_done = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_done += int'(bus.done);
    end
    chk("bb_done1", 32'(bus.done), 32'd1);
    chk("bb_res1", 32'(bus.result), 32'h3333);
    bus.op_a = 16'h0F0F;
    bus.op_b = 16'h0101;
    tick();
    chk("bb_gap", 32'({bus.busy, bus.done}), 32'd0);
    tick();
    chk("bb_restart", 32'(bus.busy), 32'd1);
    chk("bb_clear", 32'(bus.result), 32'd0);
    bus.start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_done += int'(bus.done);
    end
    chk("bb_res2", 32'(bus.result), 32'h1010);
    chk("bb_pulses", 32'(n_done), 32'd2);
    tick();

    // Reset during ADD: nibble 0 processed, then reset at edge k+2.
    set_op(16'h1235, 16'h0001, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    chk("mr_partial", 32'(bus.result), 32'h0006);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_res", 32'(bus.result), 32'd0);
    chk("mr_cout", 32'(bus.cout), 32'd0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_done += int'(bus.done);
    end
    chk("mr_nodone", 32'(n_done), 32'd0);

`ifdef NIBBLE_SUB_EN
    run_op("sub1", 16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1);
    run_op("sub2", 16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 SHALL provide parameter: NIBBLES, 4, number of 4-bit digits per operand; operand width W = 4*NIBBLES; legal range 1..8.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port: op_a  input  W  first operand; captured on accepted start.
REQ-006 SHALL have port: op_b  input  W  second operand; captured on accepted start.
REQ-007 SHALL have port: cin  input  1  carry-in for nibble 0; captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high while an operation is in progress (ADD or DONE).
REQ-009 SHALL have port: done  output  1  one-cycle pulse when result and cout are valid.
REQ-010 SHALL have port: result  output  W  registered sum; held until the next accepted start or reset.
REQ-011 SHALL have port: cout  output  1  registered carry out of the top nibble; held like result.
REQ-012 SHALL have ports: add_a, add_b  output  4 each, and add_cin  output  1; they drive the shared 4-bit adder.
REQ-013 SHALL have ports: add_sum  input  4 and add_cout  input  1; the shared adder's combinational results for the same cycle.

Function
REQ-014 SHALL implement FSM states IDLE, ADD and DONE.
REQ-015 SHALL move IDLE->ADD on a rising edge where start=1; it SHALL capture op_a, op_b and cin on that edge, clear the nibble index to 0, and clear result and cout.
REQ-016 In ADD, for nibble index i, SHALL drive add_a=op_a_reg[4i+3:4i] and add_b=op_b_reg[4i+3:4i].
REQ-017 SHALL drive add_cin from captured cin when i=0, otherwise from the carry register.
REQ-018 On each ADD edge, SHALL write add_sum into result[4i+3:4i], load add_cout into the carry register, and increment i.
REQ-019 SHALL move ADD->DONE after the edge that processes i=NIBBLES-1; on that edge cout SHALL take add_cout.
REQ-020 In DONE, SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-021 Latency: start sampled at edge k gives ADD in cycles k+1..k+NIBBLES and done high in cycle k+NIBBLES+1.
REQ-022 busy SHALL be high in ADD and DONE and low in IDLE.
REQ-023 SHALL ignore start while busy=1; no capture and no restart.
REQ-024 SHALL accept a start asserted in the cycle after DONE, giving back-to-back operations with one IDLE cycle between them.
REQ-025 SHALL drive add_a, add_b and add_cin to 0 in IDLE and DONE.
REQ-026 Overflow SHALL wrap modulo 2^W; the carry beyond bit W-1 SHALL appear only on cout.

Reset
REQ-027 When rst=1 at an edge, SHALL enter IDLE and clear busy, done, result, cout, the carry register, the index and the operand registers to 0.
REQ-028 Reset SHALL take priority over start and over any in-progress ADD; a partial result SHALL NOT be retained and done SHALL NOT pulse.

Configuration
REQ-029 With macro NIBBLE_SUB_EN defined, SHALL add port sub  input  1, captured with the operands; with sub=1, add_b SHALL be the inverted op_b nibble, the nibble-0 carry-in SHALL be forced to 1 (cin ignored), and cout=1 SHALL mean no borrow.
REQ-030 Without NIBBLE_SUB_EN, port sub SHALL NOT exist and the block SHALL perform addition only.

Verification (NIBBLES=4; shared adder modelled as {cout,sum}=a+b+cin)
REQ-031 SHALL cover: start with op_a=0x1234, op_b=0x0FFF, cin=0 at edge k -> done high in cycle k+5, result=0x2233, cout=0.
REQ-032 SHALL cover: op_a=0xFFFF, op_b=0x0001, cin=0 -> result=0x0000, cout=1; op_a=0x00FF, op_b=0x0000, cin=1 -> result=0x0100, cout=0.
REQ-033 SHALL cover: start held high throughout the first operation -> exactly one done pulse in cycle k+5, then a second operation accepted at edge k+6.
REQ-034 SHALL cover: rst=1 in cycle k+2 of an operation -> cycle k+3 shows busy=0, result=0, cout=0, and no done pulse ever appears.
REQ-035 SHALL cover, with NIBBLE_SUB_EN: sub=1, op_a=0x1000, op_b=0x0001 -> result=0x0FFF, cout=1; op_a=0x0001, op_b=0x0002 -> result=0xFFFF, cout=0.
